// File: rtl/pm_pkg.sv
// Shared definitions for the configurable serial pattern detector:
// run-state encoding, default widths and the pattern-length check.
package pm_pkg;

  localparam int PM_MAX_LEN = 8;
  localparam int PM_LEN_W   = 4;
  localparam int PM_CNT_W   = 8;
  localparam int PM_TMO_W   = 16;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_RUN  = 2'd1,
    PM_DONE = 2'd2
  } pm_state_e;

  // A run needs at least one pattern bit and no more than the window holds.
  function automatic logic pm_len_ok(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Serial shift window with fill tracking; o_hit reports whether the window
// as it will look after the current shift matches the low i_len pattern bits.
module pattern_window
  import pm_pkg::*;
#(
  parameter int MAX_LEN = PM_MAX_LEN,
  parameter int LEN_W   = PM_LEN_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit
);

  logic [MAX_LEN-1:0] r_win;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_win_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_nxt;

  // Newest bit enters at bit 0, so the pattern's bit [len-1] lines up with
  // the oldest bit still inside the compare mask.
  always_comb begin
    w_win_nxt  = {r_win[MAX_LEN-2:0], i_bit};
    w_fill_nxt = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < i_len);
    end
    o_hit = (w_fill_nxt >= i_len) && (((w_win_nxt ^ i_pattern) & w_mask) == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_win  <= w_win_nxt;
      r_fill <= w_fill_nxt;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Run controller for the serial pattern detector: latches the configuration
// on start, counts overlapping matches and ends on target, timeout or abort.
module pattern_match_ctrl
  import pm_pkg::*;
#(
  parameter int MAX_LEN = PM_MAX_LEN,
  parameter int LEN_W   = PM_LEN_W,
  parameter int CNT_W   = PM_CNT_W,
  parameter int TMO_W   = PM_TMO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               seq_in,
  input  logic               seq_valid,
  output logic               busy,
  output logic               det_o,
  output logic               done,
  output logic               timed_out,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt,
  output pm_state_e          dbg_state
);

  pm_state_e          r_state;
  pm_state_e          w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [TMO_W-1:0]   r_timeout;
  logic [TMO_W-1:0]   r_tmo_cnt;

  logic               w_hit;
  logic               w_shift;
  logic               w_accept;
  logic               w_reject;
  logic               w_det;
  logic               w_end_match;
  logic               w_end_tmo;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [TMO_W-1:0]   w_tmo_nxt;

  assign w_cnt_inc = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  assign w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
  assign w_shift   = (r_state == PM_RUN) && !abort && seq_valid;
  assign dbg_state = r_state;

  pattern_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clear   (w_accept),
    .i_shift   (w_shift),
    .i_bit     (seq_in),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_hit     (w_hit)
  );

  // Abort outranks both end conditions; a final match outranks the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_det       = 1'b0;
    w_end_match = 1'b0;
    w_end_tmo   = 1'b0;
    case (r_state)
      PM_IDLE: begin
        if (start) begin
          if (pm_len_ok(int'(cfg_len), MAX_LEN)) begin
            w_accept    = 1'b1;
            w_state_nxt = PM_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      PM_RUN: begin
        if (abort) begin
          w_state_nxt = PM_IDLE;
        end else begin
          w_det = seq_valid && w_hit;
          if (w_det && (r_target != '0) && (w_cnt_inc == r_target)) begin
            w_end_match = 1'b1;
          end else if ((r_timeout != '0) && (w_tmo_nxt == r_timeout)) begin
            w_end_tmo = 1'b1;
          end
          if (w_end_match || w_end_tmo) begin
            w_state_nxt = PM_DONE;
          end
        end
      end
      PM_DONE: w_state_nxt = PM_IDLE;
      default: w_state_nxt = PM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      det_o     <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_target  <= '0;
      r_timeout <= '0;
      r_tmo_cnt <= '0;
    end else begin
      busy      <= (w_state_nxt == PM_RUN);
      det_o     <= w_det;
      done      <= w_end_match || w_end_tmo;
      timed_out <= w_end_tmo;
      cfg_err   <= w_reject;
      if (w_accept) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_target  <= cfg_target;
        r_timeout <= cfg_timeout;
        r_tmo_cnt <= '0;
        match_cnt <= '0;
      end else begin
        if (r_state == PM_RUN && !abort) begin
          r_tmo_cnt <= w_tmo_nxt;
        end
        if (w_det) begin
          match_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl: a history-based reference model is
// compared against the outputs every cycle, plus literal per-scenario results.
module tb_pattern_match_ctrl;
  import pm_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               seq_in = 1'b0;
  logic               seq_valid = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic [TMO_W-1:0]   cfg_timeout = '0;
  logic               busy, det_o, done, timed_out, cfg_err;
  logic [CNT_W-1:0]   match_cnt;
  pm_state_e          dbg_state;

  int tests = 0;
  int fails = 0;

  // Observed per-scenario statistics
  int busy_cycles, det_seen, done_seen, err_seen, done_cnt, done_to;

  // Reference model
  int                 m_phase;  // 0 idle, 1 running, 2 finishing
  bit                 m_hist[$];
  int                 m_elapsed, m_cnt, m_len, m_target, m_tmo;
  logic [MAX_LEN-1:0] m_pat;
  logic               e_busy, e_det, e_done, e_to, e_err;
  int                 e_cnt;

  pattern_match_ctrl #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W),
    .TMO_W   (TMO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .seq_in      (seq_in),
    .seq_valid   (seq_valid),
    .busy        (busy),
    .det_o       (det_o),
    .done        (done),
    .timed_out   (timed_out),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the received bit history per run and derives the
  // outputs from the run rules directly.
  initial begin
    forever begin
      bit hit;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_hist.delete(); m_cnt = 0; m_elapsed = 0;
        e_busy = 0; e_det = 0; e_done = 0; e_to = 0; e_err = 0; e_cnt = 0;
      end else begin
        e_det = 0; e_done = 0; e_to = 0; e_err = 0;
        case (m_phase)
          0: if (start) begin
            if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
              m_pat = cfg_pattern; m_len = int'(cfg_len);
              m_target = int'(cfg_target); m_tmo = int'(cfg_timeout);
              m_hist.delete(); m_cnt = 0; m_elapsed = 0; m_phase = 1;
            end else begin
              e_err = 1;
            end
          end
          1: if (abort) begin
            m_phase = 0;
          end else begin
            m_elapsed++;
            hit = 0;
            if (seq_valid) begin
              m_hist.push_back(seq_in);
              if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
              if (m_hist.size() >= m_len) begin
                hit = 1;
                for (int j = 0; j < m_len; j++)
                  if (m_hist[m_hist.size() - 1 - j] != m_pat[j]) hit = 0;
              end
            end
            if (hit) begin
              e_det = 1;
              if (m_cnt < 255) m_cnt++;
            end
            if (hit && m_target != 0 && m_cnt == m_target) begin
              e_done = 1; m_phase = 2;
            end else if (m_tmo != 0 && m_elapsed == m_tmo) begin
              e_done = 1; e_to = 1; m_phase = 2;
            end
          end
          default: m_phase = 0;
        endcase
        e_busy = (m_phase == 1);
        e_cnt  = m_cnt;
      end
    end
  end

  // Scoreboard: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("det_o", 32'(det_o), 32'(e_det));
      chk("done", 32'(done), 32'(e_done));
      chk("timed_out", 32'(timed_out), 32'(e_to));
      chk("cfg_err", 32'(cfg_err), 32'(e_err));
      chk("match_cnt", 32'(match_cnt), 32'(e_cnt));
      if (!rst) begin
        if (busy) busy_cycles++;
        if (det_o) det_seen++;
        if (cfg_err) err_seen++;
        if (done) begin
          done_seen++;
          done_cnt = int'(match_cnt);
          done_to  = int'(timed_out);
        end
      end
    end
  end

  // Driver tasks
  task automatic drv(input logic st, input logic ab, input logic v, input logic b);
    @(negedge clk);
    start = st; abort = ab; seq_valid = v; seq_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0);
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic [CNT_W-1:0] t, input logic [TMO_W-1:0] tm);
    cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = tm;
  endtask

  task automatic clr_stats();
    busy_cycles = 0; det_seen = 0; done_seen = 0; err_seen = 0;
    done_cnt = -1; done_to = -1;
  endtask

  initial begin
    clr_stats();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_match_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Pattern 101, target 2: overlapping matches on bits 3 and 5
    set_cfg(8'b101, 4'd3, 8'd2, 16'd0);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 1); drv(0, 0, 1, 0); drv(0, 0, 1, 1); drv(0, 0, 1, 0); drv(0, 0, 1, 1);
    idle(3);
    chk("t1_det_count", 32'(det_seen), 2);
    chk("t1_done_count", 32'(done_seen), 1);
    chk("t1_done_cnt", 32'(done_cnt), 2);
    chk("t1_timed_out", 32'(done_to), 0);
    chk("t1_busy_cycles", 32'(busy_cycles), 5);

    // Timeout 10 with valid on alternating cycles
    set_cfg(8'b1, 4'd1, 8'd0, 16'd10);
    clr_stats();
    drv(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) drv(0, 0, logic'(i % 2 == 0), 1);
    idle(3);
    chk("t2_busy_cycles", 32'(busy_cycles), 10);
    chk("t2_timed_out", 32'(done_to), 1);
    chk("t2_done_cnt", 32'(done_cnt), 5);
    chk("t2_det_count", 32'(det_seen), 5);

    // Final match on the timeout cycle: match wins
    set_cfg(8'b11, 4'd2, 8'd1, 16'd2);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 1); drv(0, 0, 1, 1);
    idle(3);
    chk("t3_done_count", 32'(done_seen), 1);
    chk("t3_timed_out", 32'(done_to), 0);
    chk("t3_done_cnt", 32'(done_cnt), 1);
    chk("t3_busy_cycles", 32'(busy_cycles), 2);

    // Invalid lengths 0 and MAX_LEN+1 are rejected
    clr_stats();
    set_cfg(8'b0, 4'd0, 8'd0, 16'd0);
    drv(1, 0, 0, 0);
    drv(0, 0, 0, 0);
    set_cfg(8'b0, 4'd9, 8'd0, 16'd0);
    drv(1, 0, 0, 0);
    idle(3);
    chk("t4_err_count", 32'(err_seen), 2);
    chk("t4_busy_cycles", 32'(busy_cycles), 0);
    chk("t4_match_cnt_kept", 32'(match_cnt), 1);

    // Abort on a cycle that would match, then a fresh run
    set_cfg(8'b11, 4'd2, 8'd0, 16'd0);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 1); drv(0, 0, 1, 1);
    drv(0, 1, 1, 1);
    idle(2);
    chk("t5_det_count", 32'(det_seen), 1);
    chk("t5_done_count", 32'(done_seen), 0);
    chk("t5_match_cnt_held", 32'(match_cnt), 1);
    chk("t5_busy_cycles", 32'(busy_cycles), 3);
    chk("t5_busy_after", 32'(busy), 0);
    set_cfg(8'b1, 4'd1, 8'd1, 16'd0);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 1);
    idle(3);
    chk("t5b_done_count", 32'(done_seen), 1);
    chk("t5b_done_cnt", 32'(done_cnt), 1);

    // Reset in the middle of a run, right when det_o is high
    set_cfg(8'b101, 4'd3, 8'd0, 16'd0);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 1); drv(0, 0, 1, 0); drv(0, 0, 1, 1);
    @(negedge clk);
    start = 0; seq_valid = 0; seq_in = 0;
    chk("t6_det_before_rst", 32'(det_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_det", 32'(det_o), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_match_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // start held through RUN and DONE, config altered mid-run
    set_cfg(8'b1, 4'd1, 8'd1, 16'd0);
    clr_stats();
    drv(1, 0, 0, 0);
    drv(1, 0, 1, 1);
    set_cfg(8'b0, 4'd0, 8'd0, 16'd0);
    drv(1, 0, 0, 0);
    idle(3);
    chk("t7_done_count", 32'(done_seen), 1);
    chk("t7_err_count", 32'(err_seen), 0);
    chk("t7_busy_cycles", 32'(busy_cycles), 1);
    chk("t7_done_cnt", 32'(done_cnt), 1);
    chk("t7_det_count", 32'(det_seen), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
